vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_vga_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Arbitrates a single-port pixel memory between line-buffer prefetch bursts and a writer,
// offering one write slot between display bursts and streaming read data into a line buffer.
module vga_mem_arbiter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned BURST    = 16,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_req,
    input  logic [9:0]        line_num,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic [7:0]        lb_wdata,
    output logic              line_done,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned CW = $clog2(BURST + 1);
    localparam logic [31:0] HA = 32'(H_ACTIVE);
    localparam logic [9:0]  LAST_X = 10'(H_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, RD, WSLOT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] line_base;
    logic [9:0]        x;
    logic [CW-1:0]     burst_cnt;
    logic              rd_valid;
    logic [9:0]        rd_x;
    logic              busy_q;
    logic              overrun_q;
    logic              accept;
    logic              last_read;
    logic              slot_ok;
    logic              write_grant;

    // line_num * H_ACTIVE as a sum of shifted copies, one per set bit of the constant
    always_comb begin
        line_base = '0;
        for (int b = 0; b < 32; b++) begin
            if (HA[b]) line_base = line_base + (ADDR_W'(line_num) << b);
        end
    end

    assign accept      = line_req && (state == IDLE) && !busy_q;
    assign last_read   = (x == LAST_X);
    assign slot_ok     = ((int'(burst_cnt) + 1) >= int'(BURST)) && wr_req && !last_read;
    assign write_grant = !rst && wr_req && (((state == IDLE) && !accept) || (state == WSLOT));

    always_comb begin
        mem_we    = write_grant;
        wr_ack    = write_grant;
        mem_wdata = write_grant ? wr_data : 8'h00;
        mem_addr  = '0;
        if (write_grant) begin
            mem_addr = wr_addr;
        end else if (state == RD && !rst) begin
            mem_addr = base + ADDR_W'(x);
        end
    end

    // Read data arrives one cycle after its address, so the line-buffer side lags by one.
    assign lb_we     = rd_valid;
    assign lb_addr   = rd_x;
    assign lb_wdata  = rd_valid ? mem_rdata : 8'h00;
    assign line_done = rd_valid && (rd_x == LAST_X);
    assign busy      = busy_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            x         <= '0;
            burst_cnt <= '0;
            rd_valid  <= 1'b0;
            rd_x      <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_valid <= (state == RD);
            rd_x     <= x;
            if (line_req && !accept) overrun_q <= 1'b1;
            if (accept) busy_q <= 1'b1;
            else if (line_done) busy_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        base      <= line_base;
                        x         <= '0;
                        burst_cnt <= '0;
                        state     <= RD;
                    end
                end
                RD: begin
                    x <= x + 10'd1;
                    if (last_read) begin
                        state <= IDLE;
                    end else if (slot_ok) begin
                        state     <= WSLOT;
                        burst_cnt <= '0;
                    end else if (int'(burst_cnt) < int'(BURST)) begin
                        // saturate so a late wr_req still gets the next slot
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                WSLOT: state <= RD;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: stimulus pushes expected line-buffer and write
// transactions into queues; a negedge monitor pops and compares them as the DUT emits them.
module tb_vga_mem_arbiter;

    localparam int H = 640;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_req;
    logic [9:0]  line_num;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [7:0]  lb_wdata;
    logic        line_done;
    logic        busy;
    logic        overrun;

    vga_mem_arbiter #(.H_ACTIVE(640), .BURST(16), .ADDR_W(19)) dut (
        .clk(clk), .rst(rst), .line_req(line_req), .line_num(line_num),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .line_done(line_done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [9:0] addr; logic [7:0] data; logic done;} lb_t;
    typedef struct packed {logic [18:0] addr; logic [7:0] data;} wr_t;

    lb_t exp_lb[$];
    wr_t exp_wr[$];
    int  ack_cyc[$];
    int  cyc = 0;
    int  done_cyc = -1;
    int  busy_cnt = 0;
    int  vecs = 0;
    int  errs = 0;

    function automatic logic [7:0] hash(input logic [18:0] a);
        return a[7:0] ^ {a[14:8], a[18]} ^ 8'h3C;
    endfunction

    // Memory model: registered read, data is a hash of the address
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= hash(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        lb_t e;
        wr_t w;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (lb_we) begin
                if (exp_lb.size() == 0) begin
                    chk("lb_unexpected", 1, 0);
                end else begin
                    e = exp_lb.pop_front();
                    chk("lb_addr", 32'(lb_addr), 32'(e.addr));
                    chk("lb_wdata", 32'(lb_wdata), 32'(e.data));
                    chk("line_done", 32'(line_done), 32'(e.done));
                end
                if (line_done) done_cyc = cyc;
            end else if (line_done) begin
                chk("done_without_lb_we", 1, 0);
            end
            if (mem_we || wr_ack) begin
                chk("ack_eq_we", 32'(wr_ack), 32'(mem_we));
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(w.data));
                end
                ack_cyc.push_back(cyc);
            end
        end
    end

    task automatic start_line(input int num, output int t0);
        lb_t e;
        line_req = 1'b1;
        line_num = 10'(num);
        t0 = cyc;
        done_cyc = -1;
        busy_cnt = 0;
        for (int i = 0; i < H; i++) begin
            e.addr = 10'(i);
            e.data = hash(19'(num * H + i));
            e.done = (i == H - 1);
            exp_lb.push_back(e);
        end
        @(posedge clk);
        #1;
        line_req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_cyc < 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cyc < 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_writes(input int n, input logic [18:0] a0, input logic [7:0] d0);
        wr_t w;
        int t;
        for (int i = 0; i < n; i++) begin
            wr_req = 1'b1;
            wr_addr = a0 + 19'(i);
            wr_data = d0 + 8'(i);
            w.addr = wr_addr;
            w.data = wr_data;
            exp_wr.push_back(w);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!wr_ack && t < 2000);
            if (!wr_ack) chk("wr_ack_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        wr_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int w0;
        int mism;
        rst = 1'b1;
        line_req = 1'b0;
        line_num = '0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_lb_we", 32'(lb_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain line fetch, line 2
        start_line(2, t0);
        wait_done("l2");
        chk("l2_done_offset", 32'(done_cyc - t0), 641);
        repeat (3) @(posedge clk);
        #1;
        chk("l2_busy_cycles", 32'(busy_cnt), 641);
        chk("l2_queue_empty", 32'(exp_lb.size()), 0);

        // Back-to-back idle writes
        ack_cyc.delete();
        w0 = cyc;
        run_writes(2, 19'd100, 8'hAA);
        chk("idle_ack_count", 32'(ack_cyc.size()), 2);
        if (ack_cyc.size() == 2) begin
            chk("idle_ack0_cycle", 32'(ack_cyc[0] - w0), 0);
            chk("idle_ack1_cycle", 32'(ack_cyc[1] - w0), 1);
        end

        // Line with constant writer pressure, line_req and wr_req together
        @(posedge clk);
        #1;
        ack_cyc.delete();
        fork
            begin
                start_line(7, t0);
                wait_done("l7");
            end
            run_writes(40, 19'h01000, 8'h10);
        join
        chk("l7_done_offset", 32'(done_cyc - t0), 680);
        chk("l7_ack_count", 32'(ack_cyc.size()), 40);
        if (ack_cyc.size() > 0) chk("l7_first_ack", 32'(ack_cyc[0] - t0), 17);
        mism = 0;
        foreach (ack_cyc[k]) if (ack_cyc[k] - t0 != 17 * (k + 1)) mism++;
        chk("l7_slot_pattern", 32'(mism), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("l7_busy_cycles", 32'(busy_cnt), 680);
        chk("l7_overrun_clear", 32'(overrun), 0);

        // Second line_req mid-line is dropped and flagged
        start_line(5, t0);
        repeat (300) @(posedge clk);
        #1;
        line_req = 1'b1;
        line_num = 10'd9;
        @(posedge clk);
        #1;
        line_req = 1'b0;
        wait_done("l5");
        chk("l5_done_offset", 32'(done_cyc - t0), 641);
        repeat (3) @(posedge clk);
        #1;
        chk("l5_overrun", 32'(overrun), 1);
        chk("l5_queue_empty", 32'(exp_lb.size()), 0);

        // Reset mid-line at x=200
        start_line(3, t0);
        repeat (200) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_queue_left", 32'(exp_lb.size()), 440);
        exp_lb.delete();
        @(negedge clk);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        chk("abort_mem_we", 32'(mem_we), 0);
        chk("abort_wr_ack", 32'(wr_ack), 0);
        chk("abort_lb_we", 32'(lb_we), 0);
        chk("abort_lb_addr", 32'(lb_addr), 0);
        chk("abort_line_done", 32'(line_done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_overrun", 32'(overrun), 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_cyc), 32'(-1));
        @(posedge clk);
        #1;
        start_line(4, t0);
        wait_done("l4");
        chk("l4_done_offset", 32'(done_cyc - t0), 641);

        repeat (3) @(posedge clk);
        #1;
        chk("final_lb_empty", 32'(exp_lb.size()), 0);
        chk("final_wr_empty", 32'(exp_wr.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
